// File: rtl/dma_descriptor_queue.sv
// dma_descriptor_queue
//
// Upstream feeder of the DMA engine. Software assembles a multi-word
// descriptor one CSR word at a time into a staging register and then commits
// it with a push pulse into a DEPTH-entry FIFO. The FIFO head is presented
// show-ahead to the engine, which consumes it with rdack while not_empty is
// high. Occupancy and sticky overflow/underflow flags feed the CSR status
// block.
//
// Ports:
//   clk                        clock, all logic on the rising edge
//   reset                      synchronous active-high reset
//   csr_wr_en/idx/data         write one staging word
//   csr_push                   commit staging (with same-cycle word merged)
//   csr_flush                  drop every queued descriptor
//   err_clear                  clear sticky error flags
//   descriptor_fifo_not_empty  head entry valid
//   descriptor_fifo_rdack      engine consumed the head entry
//   descriptor                 head entry, word 0 in the LSBs
//   fifo_count/fifo_full       occupancy 0..DEPTH and full flag
//   overflow_err               sticky: push dropped while full
//   underflow_err              sticky: rdack while empty
module dma_descriptor_queue #(
    parameter int WORD_W  = 64,
    parameter int N_WORDS = 4,
    parameter int DEPTH   = 16,
    localparam int DESC_W = N_WORDS * WORD_W,
    localparam int IDX_W  = $clog2(N_WORDS),
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              csr_wr_en,
    input  logic [IDX_W-1:0]  csr_wr_idx,
    input  logic [WORD_W-1:0] csr_wr_data,
    input  logic              csr_push,
    input  logic              csr_flush,
    input  logic              err_clear,
    output logic              descriptor_fifo_not_empty,
    input  logic              descriptor_fifo_rdack,
    output logic [DESC_W-1:0] descriptor,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              fifo_full,
    output logic              overflow_err,
    output logic              underflow_err
);

    logic [N_WORDS-1:0][WORD_W-1:0] staging_q, staging_d;
    logic [DESC_W-1:0]              mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             not_empty_q, not_empty_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic push_ok, rd_ok, ovf_set, unf_set;

    // staging_d already holds this cycle's word, so a push in the same cycle
    // as a write enqueues the merged descriptor.
    for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_stage
        assign staging_d[gi] = (csr_wr_en && csr_wr_idx == IDX_W'(gi))
                               ? csr_wr_data : staging_q[gi];
    end

    always_comb begin
        // Flush masks push and rdack completely, including their error side effects.
        rd_ok   = descriptor_fifo_rdack && not_empty_q && !csr_flush;
        // A full queue still accepts a push when the head leaves the same cycle.
        push_ok = csr_push && !csr_flush && (!full_q || rd_ok);
        ovf_set = csr_push && !csr_flush && full_q && !rd_ok;
        unf_set = descriptor_fifo_rdack && !csr_flush && !not_empty_q;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (csr_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_ok)   rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(rd_ok);
        end
        full_d      = (count_d == CNT_W'(DEPTH));
        not_empty_d = (count_d != '0);

        // A set event beats a simultaneous clear.
        ovf_d = ovf_set ? 1'b1 : (err_clear ? 1'b0 : ovf_q);
        unf_d = unf_set ? 1'b1 : (err_clear ? 1'b0 : unf_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            staging_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            not_empty_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            staging_q   <= staging_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            not_empty_q <= not_empty_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    // Storage is not reset; validity is tracked purely by the pointers/count.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[wr_ptr_q] <= staging_d;
        end
    end

    // Show-ahead read from registered pointer; forced to zero while empty so
    // the output is clean after reset.
    assign descriptor                = not_empty_q ? mem[rd_ptr_q] : '0;
    assign descriptor_fifo_not_empty = not_empty_q;
    assign fifo_count                = count_q;
    assign fifo_full                 = full_q;
    assign overflow_err              = ovf_q;
    assign underflow_err             = unf_q;

endmodule
